// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Definitions shared by the VGA controller and the VRAM write path:
//   screen geometry of the 160x100 RGB332 frame buffer, VRAM address width,
//   and the fill-engine state encoding.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int SCR_W         = 160;           // pixels per row, also VRAM row stride
    localparam int SCR_H         = 100;           // rows
    localparam int AW            = 14;            // VRAM address width
    localparam int VRAM_SIZE     = SCR_W * SCR_H; // 16000 bytes
    localparam int MAX_CPU_BURST = 4;             // CPU grants in a row before a fill slot

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_SETUP = 2'd1,
        FILL_RUN   = 2'd2,
        FILL_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/vram_fill_engine.sv
// -----------------------------------------------------------------------------
// vram_fill_engine
//   Rectangle-fill engine. Latches a rectangle on fill_start_i, clips it to
//   the screen, then walks it row by row, presenting one pixel write at a
//   time to the arbiter.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fill_start_i             pulse, latch fill_*_i and begin (IDLE only)
//   fill_abort_i             pulse, cancel (SETUP/RUN only)
//   fill_x_i/y_i/w_i/h_i     rectangle origin and size in pixels
//   fill_color_i             RGB332 fill value
//   fill_req_o               a pixel write is pending (state RUN)
//   fill_gnt_i               the arbiter accepted the pending write this cycle
//   fill_addr_o/fill_data_o  address/data of the pending write
//   fill_busy_o              engine not idle
//   fill_done_o              one-cycle pulse after the last pixel was granted
//   state_o                  current FSM state (debug)
//
// Handshake: fill_req_o/fill_gnt_i is a valid/ready pair. A write transfers in
// any cycle where both are high; address and data then advance on that edge.
// fill_req_o never depends on fill_gnt_i.
// -----------------------------------------------------------------------------
module vram_fill_engine #(
    parameter int SCR_W = vga_pkg::SCR_W,
    parameter int SCR_H = vga_pkg::SCR_H,
    parameter int AW    = vga_pkg::AW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fill_start_i,
    input  logic                 fill_abort_i,
    input  logic [7:0]           fill_x_i,
    input  logic [6:0]           fill_y_i,
    input  logic [7:0]           fill_w_i,
    input  logic [6:0]           fill_h_i,
    input  logic [7:0]           fill_color_i,
    output logic                 fill_req_o,
    input  logic                 fill_gnt_i,
    output logic [AW-1:0]        fill_addr_o,
    output logic [7:0]           fill_data_o,
    output logic                 fill_busy_o,
    output logic                 fill_done_o,
    output vga_pkg::fill_state_e state_o
);

    vga_pkg::fill_state_e state_q, state_d;

    logic [7:0]    x0_q, x0_d;
    logic [6:0]    y0_q, y0_d;
    logic [7:0]    w_q, w_d;
    logic [6:0]    h_q, h_d;
    logic [7:0]    color_q, color_d;
    logic [7:0]    cur_x_q, cur_x_d;
    logic [6:0]    cur_y_q, cur_y_d;
    logic [AW-1:0] row_base_q, row_base_d;

    // Clipping works from the latched rectangle, so the sums are only
    // meaningful from SETUP onwards. The wide sums cannot wrap.
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic [7:0] x_end;
    logic [6:0] y_end;
    logic       degenerate;
    logic       last_col;
    logic       last_row;

    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, w_q};
        y_sum      = {1'b0, y0_q} + {1'b0, h_q};
        x_end      = (x_sum > 9'(SCR_W)) ? 8'(SCR_W) : x_sum[7:0];
        y_end      = (y_sum > 8'(SCR_H)) ? 7'(SCR_H) : y_sum[6:0];
        degenerate = (w_q == 8'd0) || (h_q == 7'd0) ||
                     (x0_q >= 8'(SCR_W)) || (y0_q >= 7'(SCR_H));
        last_col   = (cur_x_q == x_end - 8'd1);
        last_row   = (cur_y_q == y_end - 7'd1);
    end

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        row_base_d = row_base_q;

        unique case (state_q)
            vga_pkg::FILL_IDLE: begin
                if (fill_start_i) begin
                    x0_d    = fill_x_i;
                    y0_d    = fill_y_i;
                    w_d     = fill_w_i;
                    h_d     = fill_h_i;
                    color_d = fill_color_i;
                    state_d = vga_pkg::FILL_SETUP;
                end
            end

            vga_pkg::FILL_SETUP: begin
                if (fill_abort_i) begin
                    state_d = vga_pkg::FILL_IDLE;
                end else if (degenerate) begin
                    state_d = vga_pkg::FILL_DONE;
                end else begin
                    row_base_d = AW'(y0_q) * AW'(SCR_W);
                    cur_x_d    = x0_q;
                    cur_y_d    = y0_q;
                    state_d    = vga_pkg::FILL_RUN;
                end
            end

            vga_pkg::FILL_RUN: begin
                if (fill_gnt_i) begin
                    if (last_col) begin
                        if (last_row) begin
                            state_d = vga_pkg::FILL_DONE;
                        end else begin
                            cur_x_d    = x0_q;
                            cur_y_d    = cur_y_q + 7'd1;
                            row_base_d = row_base_q + AW'(SCR_W);
                        end
                    end else begin
                        cur_x_d = cur_x_q + 8'd1;
                    end
                end
                // Abort wins over a same-cycle last-pixel grant; the granted
                // write itself is already captured by the output registers.
                if (fill_abort_i) begin
                    state_d = vga_pkg::FILL_IDLE;
                end
            end

            vga_pkg::FILL_DONE: begin
                state_d = vga_pkg::FILL_IDLE;
            end

            default: begin
                state_d = vga_pkg::FILL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= vga_pkg::FILL_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            row_base_q <= row_base_d;
        end
    end

    assign fill_req_o  = (state_q == vga_pkg::FILL_RUN);
    assign fill_addr_o = row_base_q + AW'(cur_x_q);
    assign fill_data_o = color_q;
    assign fill_busy_o = (state_q != vga_pkg::FILL_IDLE);
    assign fill_done_o = (state_q == vga_pkg::FILL_DONE);
    assign state_o     = state_q;

endmodule

// File: rtl/vram_write_arbiter.sv
// -----------------------------------------------------------------------------
// vram_write_arbiter
//   Owns the single VRAM write port and shares it between CPU byte writes and
//   the rectangle-fill engine. At most one write per cycle; the port outputs
//   are registered, so a grant in cycle N shows as vram_wr=1 in cycle N+1.
//
// Ports
//   cpu_clk, reset_n            clock, asynchronous active-low reset
//   cpu_req/cpu_addr/cpu_data   CPU write request, held stable until cpu_ack
//   cpu_ack                     one-cycle pulse, same cycle as the CPU's vram_wr
//   fill_start/fill_abort       fill control pulses
//   fill_x/y/w/h/color          fill rectangle and colour
//   fill_busy/fill_done         fill status
//   vram_wr/vram_addr/vram_data VRAM write port (to the VGA controller)
//   dbg_fill_state              fill FSM state (debug)
//
// CPU handshake: cpu_req is a valid that must stay high with address/data
// stable until cpu_ack. The request is considered only while cpu_ack is low,
// so a request still high in the ack cycle is treated as the next transfer,
// which limits the CPU to one write every two cycles.
// -----------------------------------------------------------------------------
module vram_write_arbiter #(
    parameter int SCR_W         = vga_pkg::SCR_W,
    parameter int SCR_H         = vga_pkg::SCR_H,
    parameter int AW            = vga_pkg::AW,
    parameter int MAX_CPU_BURST = vga_pkg::MAX_CPU_BURST
) (
    input  logic                 cpu_clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [7:0]           cpu_data,
    output logic                 cpu_ack,
    input  logic                 fill_start,
    input  logic                 fill_abort,
    input  logic [7:0]           fill_x,
    input  logic [6:0]           fill_y,
    input  logic [7:0]           fill_w,
    input  logic [6:0]           fill_h,
    input  logic [7:0]           fill_color,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 vram_wr,
    output logic [AW-1:0]        vram_addr,
    output logic [7:0]           vram_data,
    output vga_pkg::fill_state_e dbg_fill_state
);

    localparam int VRAM_SIZE = SCR_W * SCR_H;
    localparam int BW        = $clog2(MAX_CPU_BURST + 1);

    logic          fill_req;
    logic          fill_gnt;
    logic [AW-1:0] fill_addr;
    logic [7:0]    fill_data;

    vram_fill_engine #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H),
        .AW    (AW)
    ) u_fill (
        .clk_i        (cpu_clk),
        .rst_ni       (reset_n),
        .fill_start_i (fill_start),
        .fill_abort_i (fill_abort),
        .fill_x_i     (fill_x),
        .fill_y_i     (fill_y),
        .fill_w_i     (fill_w),
        .fill_h_i     (fill_h),
        .fill_color_i (fill_color),
        .fill_req_o   (fill_req),
        .fill_gnt_i   (fill_gnt),
        .fill_addr_o  (fill_addr),
        .fill_data_o  (fill_data),
        .fill_busy_o  (fill_busy),
        .fill_done_o  (fill_done),
        .state_o      (dbg_fill_state)
    );

    logic          cpu_ack_q, cpu_ack_d;
    logic          vram_wr_q, vram_wr_d;
    logic [AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]    vram_data_q, vram_data_d;
    logic [BW-1:0] burst_q, burst_d;

    logic cpu_elig;
    logic cpu_gnt;
    logic cpu_in_range;
    logic burst_full;

    always_comb begin
        cpu_elig     = cpu_req && !cpu_ack_q;
        burst_full   = (burst_q == BW'(MAX_CPU_BURST));
        // The fill takes the slot when it is alone or the CPU used up its burst.
        fill_gnt     = fill_req && (!cpu_elig || burst_full);
        cpu_gnt      = cpu_elig && !fill_gnt;
        cpu_in_range = (cpu_addr < AW'(VRAM_SIZE));

        burst_d = burst_q;
        if (fill_gnt || dbg_fill_state != vga_pkg::FILL_RUN) begin
            burst_d = '0;
        end else if (cpu_gnt) begin
            burst_d = burst_q + BW'(1);
        end

        // Out-of-range CPU writes are acked but never strobe the memory.
        cpu_ack_d   = cpu_gnt;
        vram_wr_d   = fill_gnt || (cpu_gnt && cpu_in_range);
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        if (fill_gnt) begin
            vram_addr_d = fill_addr;
            vram_data_d = fill_data;
        end else if (cpu_gnt) begin
            vram_addr_d = cpu_addr;
            vram_data_d = cpu_data;
        end
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack_q   <= 1'b0;
            vram_wr_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
            burst_q     <= '0;
        end else begin
            cpu_ack_q   <= cpu_ack_d;
            vram_wr_q   <= vram_wr_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
            burst_q     <= burst_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign vram_wr   = vram_wr_q;
    assign vram_addr = vram_addr_q;
    assign vram_data = vram_data_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
module tb_vram_write_arbiter;

  localparam int SW = 160;
  localparam int SH = 100;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_ack;
  logic        fill_start = 1'b0;
  logic        fill_abort = 1'b0;
  logic [7:0]  fill_x = '0;
  logic [6:0]  fill_y = '0;
  logic [7:0]  fill_w = '0;
  logic [6:0]  fill_h = '0;
  logic [7:0]  fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic        vram_wr;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  vga_pkg::fill_state_e dbg_fill_state;

  vram_write_arbiter dut (
    .cpu_clk        (cpu_clk),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .cpu_ack        (cpu_ack),
    .fill_start     (fill_start),
    .fill_abort     (fill_abort),
    .fill_x         (fill_x),
    .fill_y         (fill_y),
    .fill_w         (fill_w),
    .fill_h         (fill_h),
    .fill_color     (fill_color),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .vram_wr        (vram_wr),
    .vram_addr      (vram_addr),
    .vram_data      (vram_data),
    .dbg_fill_state (dbg_fill_state)
  );

  // ---------------- clock ----------------
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int wr_cnt = 0;
  int fill_wr_cnt = 0;
  int cpu_ack_cnt = 0;
  int done_cnt = 0;
  int cpu_run = 0;
  bit mon_en = 1'b0;

  logic [21:0] fill_exp_q[$];  // {addr, data}
  logic [22:0] cpu_exp_q[$];   // {in_range, addr, data}
  logic [21:0] mon_fill_e;
  logic [22:0] mon_cpu_e;

  // Monitor: samples on the falling edge, pops expected writes.
  always @(negedge cpu_clk) begin
    if (mon_en) begin
      if (fill_done === 1'b1) done_cnt++;
      if (cpu_ack === 1'b1) begin
        cpu_ack_cnt++;
        n_vec++;
        if (cpu_exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL cpu_ack_unexpected: got ack with no pending CPU request");
        end else begin
          mon_cpu_e = cpu_exp_q.pop_front();
          if (vram_wr !== mon_cpu_e[22] ||
              (mon_cpu_e[22] && {vram_addr, vram_data} !== mon_cpu_e[21:0])) begin
            n_miss++;
            $display("FAIL cpu_write: got wr=%b addr=%0d data=%h, want wr=%b addr=%0d data=%h",
                     vram_wr, vram_addr, vram_data, mon_cpu_e[22], mon_cpu_e[21:8], mon_cpu_e[7:0]);
          end
        end
        if (vram_wr === 1'b1) begin
          wr_cnt++;
          cpu_run++;
          if (fill_busy === 1'b1) begin
            n_vec++;
            if (cpu_run > 4) begin
              n_miss++;
              $display("FAIL cpu_burst: got %0d consecutive CPU writes during fill, want <= 4", cpu_run);
            end
          end
        end
      end else if (vram_wr === 1'b1) begin
        wr_cnt++;
        fill_wr_cnt++;
        cpu_run = 0;
        n_vec++;
        if (fill_exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL fill_write_unexpected: got addr=%0d data=%h, want no write", vram_addr, vram_data);
        end else begin
          mon_fill_e = fill_exp_q.pop_front();
          if ({vram_addr, vram_data} !== mon_fill_e) begin
            n_miss++;
            $display("FAIL fill_write: got addr=%0d data=%h, want addr=%0d data=%h",
                     vram_addr, vram_data, mon_fill_e[21:8], mon_fill_e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Tasks start and end at the drive point, 1 ns after a rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push_fill(input int x, input int y, input int w, input int h, input logic [7:0] c);
    int xe, ye;
    logic [13:0] a;
    xe = (x + w > SW) ? SW : x + w;
    ye = (y + h > SH) ? SH : y + h;
    for (int r = y; r < ye; r++) begin
      for (int col = x; col < xe; col++) begin
        a = 14'(r * SW + col);
        fill_exp_q.push_back({a, c});
      end
    end
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h, input logic [7:0] c);
    push_fill(x, y, w, h, c);
    fill_x     = 8'(x);
    fill_y     = 7'(y);
    fill_w     = 8'(w);
    fill_h     = 7'(h);
    fill_color = c;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_fill_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (fill_busy !== 1'b0 && n < budget);
    n_vec++;
    if (fill_busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s_timeout: fill_busy=%b after %0d cycles, want 0", name, fill_busy, n);
    end
    tick();
  endtask

  // One CPU transfer; cpu_req stays high on return so a caller can chain.
  task automatic cpu_xfer(input logic [13:0] a, input logic [7:0] d);
    int n;
    cpu_exp_q.push_back({(a < 14'd16000), a, d});
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    n = 0;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (cpu_ack !== 1'b1 && n < 100);
    n_vec++;
    if (cpu_ack !== 1'b1) begin
      n_miss++;
      $display("FAIL cpu_ack_timeout: cpu_ack=%b after %0d cycles for addr=%0d, want 1", cpu_ack, n, a);
    end
    tick();
  endtask

  task automatic cpu_one(input logic [13:0] a, input logic [7:0] d);
    cpu_xfer(a, d);
    cpu_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    start_fill(0, 0, 160, 100, 8'hA5);
    cpu_req  = 1'b1;
    cpu_addr = 14'd5;
    cpu_data = 8'h77;
    repeat (4) tick();
    @(negedge cpu_clk);
    n_vec++;
    if (vram_wr !== 1'b1) begin
      n_miss++;
      $display("FAIL pre_reset_activity: got vram_wr=%b, want 1", vram_wr);
    end
    @(posedge cpu_clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (vram_wr !== 1'b0 || vram_addr !== 14'd0 || vram_data !== 8'd0) begin
      n_miss++;
      $display("FAIL async_reset_port: got wr=%b addr=%0d data=%h, want 0 0 00", vram_wr, vram_addr, vram_data);
    end
    n_vec++;
    if (cpu_ack !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset_status: got ack=%b busy=%b done=%b, want 0 0 0", cpu_ack, fill_busy, fill_done);
    end
    cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (vram_wr !== 1'b0 || fill_busy !== 1'b0 || cpu_ack !== 1'b0 ||
        dbg_fill_state !== vga_pkg::FILL_IDLE) begin
      n_miss++;
      $display("FAIL post_reset_idle: got wr=%b busy=%b ack=%b state=%0d, want 0 0 0 0",
               vram_wr, fill_busy, cpu_ack, dbg_fill_state);
    end
    fill_exp_q.delete();
    cpu_exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_single_write();
    int wr0, ack0;
    wr0  = wr_cnt;
    ack0 = cpu_ack_cnt;
    cpu_exp_q.push_back({1'b1, 14'h0123, 8'hE3});
    cpu_req  = 1'b1;
    cpu_addr = 14'h0123;
    cpu_data = 8'hE3;
    @(negedge cpu_clk);
    n_vec++;
    if (cpu_ack !== 1'b0 || vram_wr !== 1'b0) begin
      n_miss++;
      $display("FAIL single_latency_early: got ack=%b wr=%b in grant cycle, want 0 0", cpu_ack, vram_wr);
    end
    @(negedge cpu_clk);
    n_vec++;
    if (cpu_ack !== 1'b1 || vram_wr !== 1'b1 || vram_addr !== 14'h0123 || vram_data !== 8'hE3) begin
      n_miss++;
      $display("FAIL single_write: got ack=%b wr=%b addr=%h data=%h, want 1 1 0123 e3",
               cpu_ack, vram_wr, vram_addr, vram_data);
    end
    tick();
    cpu_req = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (wr_cnt - wr0 != 1 || cpu_ack_cnt - ack0 != 1) begin
      n_miss++;
      $display("FAIL single_count: got %0d writes %0d acks, want 1 1", wr_cnt - wr0, cpu_ack_cnt - ack0);
    end
  endtask

  task automatic test_cpu_random();
    int wr0, ack0, n_in;
    logic [13:0] a;
    wr0  = wr_cnt;
    ack0 = cpu_ack_cnt;
    n_in = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) a = 14'($urandom_range(16000, 16383));
      else            a = 14'($urandom_range(0, 15999));
      if (a < 14'd16000) n_in++;
      if (i % 3 == 0) cpu_one(a, 8'($urandom_range(0, 255)));
      else            cpu_xfer(a, 8'($urandom_range(0, 255)));
    end
    cpu_req = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (cpu_ack_cnt - ack0 != 24 || wr_cnt - wr0 != n_in || cpu_exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL cpu_random: got %0d acks %0d writes %0d pending, want 24 %0d 0",
               cpu_ack_cnt - ack0, wr_cnt - wr0, cpu_exp_q.size(), n_in);
    end
  endtask

  task automatic test_clipped_fill();
    int fw0, d0;
    fw0 = fill_wr_cnt;
    d0  = done_cnt;
    start_fill(158, 98, 5, 5, 8'h1C);
    wait_fill_idle(50, "clipped");
    n_vec++;
    if (fill_wr_cnt - fw0 != 4 || done_cnt - d0 != 1 || fill_exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL clipped_fill: got %0d writes %0d done %0d pending, want 4 1 0",
               fill_wr_cnt - fw0, done_cnt - d0, fill_exp_q.size());
    end
  endtask

  task automatic test_degenerate(input int x, input int w, input string name);
    int wr0, d0, busy_n;
    wr0 = wr_cnt;
    d0  = done_cnt;
    busy_n = 0;
    start_fill(x, 10, w, 4, 8'hFF);
    for (int k = 0; k < 20; k++) begin
      @(negedge cpu_clk);
      if (fill_busy === 1'b1) busy_n++;
      else break;
    end
    tick();
    n_vec++;
    if (busy_n != 2 || done_cnt - d0 != 1 || wr_cnt - wr0 != 0) begin
      n_miss++;
      $display("FAIL %s: got busy %0d cycles %0d done %0d writes, want 2 1 0",
               name, busy_n, done_cnt - d0, wr_cnt - wr0);
    end
  endtask

  task automatic test_contention();
    int fw0, d0, ack0;
    fw0  = fill_wr_cnt;
    d0   = done_cnt;
    ack0 = cpu_ack_cnt;
    fork
      start_fill(0, 0, 160, 100, 8'($urandom_range(0, 255)));
      begin
        for (int i = 0; i < 40; i++)
          cpu_xfer(14'($urandom_range(0, 15999)), 8'($urandom_range(0, 255)));
        cpu_req = 1'b0;
      end
    join
    wait_fill_idle(40000, "contention");
    n_vec++;
    if (fill_wr_cnt - fw0 != 16000 || done_cnt - d0 != 1) begin
      n_miss++;
      $display("FAIL contention_fill: got %0d writes %0d done, want 16000 1", fill_wr_cnt - fw0, done_cnt - d0);
    end
    n_vec++;
    if (cpu_ack_cnt - ack0 != 40 || cpu_exp_q.size() != 0 || fill_exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL contention_cpu: got %0d acks %0d cpu pending %0d fill pending, want 40 0 0",
               cpu_ack_cnt - ack0, cpu_exp_q.size(), fill_exp_q.size());
    end
  endtask

  task automatic test_abort();
    int fw0, d0, snap, n;
    fw0 = fill_wr_cnt;
    d0  = done_cnt;
    start_fill(0, 0, 160, 10, 8'h3C);
    n = 0;
    while (fill_wr_cnt - fw0 < 10 && n < 100) begin
      tick();
      n++;
    end
    n_vec++;
    if (fill_wr_cnt - fw0 < 10) begin
      n_miss++;
      $display("FAIL abort_progress: got %0d writes, want >= 10", fill_wr_cnt - fw0);
    end
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    snap = fill_wr_cnt;
    n_vec++;
    if (fill_busy !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_busy: got fill_busy=%b one cycle after abort, want 0", fill_busy);
    end
    repeat (5) tick();
    n_vec++;
    if (fill_wr_cnt - snap > 1 || done_cnt - d0 != 0) begin
      n_miss++;
      $display("FAIL abort_stop: got %0d further writes %0d done, want <= 1 and 0",
               fill_wr_cnt - snap, done_cnt - d0);
    end
    fill_exp_q.delete();
    fw0 = fill_wr_cnt;
    d0  = done_cnt;
    start_fill(10, 20, 3, 2, 8'hC7);
    wait_fill_idle(50, "after_abort");
    n_vec++;
    if (fill_wr_cnt - fw0 != 6 || done_cnt - d0 != 1 || fill_exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL after_abort_fill: got %0d writes %0d done %0d pending, want 6 1 0",
               fill_wr_cnt - fw0, done_cnt - d0, fill_exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_cpu_random();
    test_clipped_fill();
    test_degenerate(20, 0, "degenerate_w0");
    test_degenerate(200, 5, "degenerate_x200");
    test_contention();
    test_abort();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    n_miss++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Owns the single write port of the 160x100 RGB332 video memory.
- Shares that port between two requesters: CPU single-byte writes, and a built-in rectangle-fill engine used for clear-screen and box drawing.
- Output port drives the VGA controller's write interface directly (write strobe, 14-bit address, 8-bit data), all in the CPU clock domain.

Parameters:
- SCR_W, 160, screen width in pixels; also the row stride of VRAM.
- SCR_H, 100, screen height in pixels.
- AW, 14, VRAM address width.
- MAX_CPU_BURST, 4, maximum consecutive CPU grants while a fill is active before the fill gets one slot.

Ports:
- cpu_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU write request; hold with addr/data stable until cpu_ack
- cpu_addr  in  AW  CPU write address
- cpu_data  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU write accepted
- fill_start  in  1  pulse: begin fill with the current fill_* values
- fill_abort  in  1  pulse: cancel the active fill
- fill_x  in  8  left column
- fill_y  in  7  top row
- fill_w  in  8  width in pixels
- fill_h  in  7  height in pixels
- fill_color  in  8  RGB332 fill value
- fill_busy  out  1  fill engine not idle
- fill_done  out  1  one-cycle pulse: fill completed
- vram_wr  out  1  VRAM write strobe
- vram_addr  out  AW  VRAM write address
- vram_data  out  8  VRAM write data

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - FSM in IDLE.
  - CPU burst counter 0.
- Output registers: vram_wr, vram_addr and vram_data are registered, one write per cycle at most. A grant in cycle N produces vram_wr=1 in cycle N+1.
- CPU handshake:
  - The CPU is eligible when cpu_req=1 and cpu_ack=0.
  - When granted, cpu_ack=1 in N+1, in the same cycle as its vram_wr.
  - Back-to-back CPU writes therefore reach at most one every 2 cycles.
- CPU out-of-range addresses: cpu_addr >= SCR_W*SCR_H (16000) is still granted and acked, but vram_wr stays 0 for that slot.
- Arbitration:
  - Only the CPU eligible: CPU wins.
  - Only the fill in RUN: fill wins.
  - Both eligible: the CPU wins unless the burst counter equals MAX_CPU_BURST; then the fill wins.
  - Burst counter: increments on each CPU grant made while the FSM is in RUN. Clears on a fill grant and on leaving RUN.
- FSM states: IDLE, SETUP, RUN, DONE.
  - IDLE: fill_start=1 latches fill_x/y/w/h/color and moves to SETUP.
  - SETUP (1 cycle):
    - x_end = min(fill_x+fill_w, SCR_W); y_end = min(fill_y+fill_h, SCR_H). Sums use 9-bit / 8-bit widths, no wrap.
    - If fill_w=0, fill_h=0, fill_x>=SCR_W or fill_y>=SCR_H: go to DONE with zero writes.
    - Otherwise: row_base = fill_y*SCR_W (constant multiply), cur_x = fill_x, go to RUN.
  - RUN:
    - Each fill grant writes addr = row_base + cur_x, then advances cur_x.
    - When cur_x reaches x_end-1: cur_x = fill_x, row_base += SCR_W, row increments.
    - After the last pixel (row y_end-1, column x_end-1) is granted: go to DONE.
  - DONE (1 cycle): fill_done=1, then IDLE.
- fill_busy = 1 in SETUP, RUN and DONE.
- fill_start outside IDLE is ignored.
- fill_abort in SETUP or RUN:
  - Next state is IDLE; no fill_done.
  - A write already granted in that cycle still completes.
  - fill_abort has priority over a same-cycle last-pixel grant: no DONE.
  - fill_abort in IDLE or DONE is ignored.
- Reset mid-fill: immediate return to IDLE, all outputs 0, no pending CPU ack retained.

Decomposition:
- Shared package vga_pkg:
  - SCR_W, SCR_H, AW, VRAM_SIZE=16000.
  - Fill FSM state enum.
  - Must also be used by the VGA controller.
- One natural sub-module: vram_fill_engine. It holds the FSM, clipping and address generation, and exposes fill_req/fill_gnt, addr and data. The top level holds the arbiter and output registers.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release, idle with vram_wr=0.
- Single CPU write: cpu_req with addr 0x0123, data 0xE3 -> one cycle of vram_wr=1, addr=0x0123, data=0xE3, with cpu_ack=1 in the same cycle; exactly one write.
- Clipped fill: x=158, y=98, w=5, h=5, color=0x1C -> exactly 4 writes to addresses 15838, 15839, 15998, 15999, data 0x1C, then one fill_done pulse; fill_busy then drops.
- Degenerate fill: w=0 (and separately x=200) -> fill_busy high for 2 cycles, fill_done once, zero vram_wr.
- Contention: full-screen fill plus a CPU issuing back-to-back requests -> no grant pattern has 5 consecutive CPU writes; the fill still completes 16000 writes; every CPU request is acked exactly once.
- Abort: fill_abort after 10 fill writes -> at most 1 further write, no fill_done, fill_busy=0 within 1 cycle; a subsequent fill_start works normally.
